// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES-128 core between two requesters.
// Define AES_TIMEOUT_EN to add the RUN-state watchdog (and its TIMEOUT_CYC parameter).

module aes_core_arbiter #(
    parameter int DATA_W   = 128,
    parameter int CORE_GAP = 2
`ifdef AES_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic              AES_clk,
    input  logic              AES_rst,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [DATA_W-1:0] req0_key,
    input  logic [DATA_W-1:0] req1_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              core_en,
    output logic [DATA_W-1:0] core_data_in,
    output logic [DATA_W-1:0] core_key_in,
    input  logic [DATA_W-1:0] core_data_out,
    input  logic              core_data_out_valid
);

    localparam int GAP_W = (CORE_GAP > 1) ? $clog2(CORE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CORE_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t            state_r;
    logic              rr_ptr_r;
    logic              id_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic              grant0_s;
    logic              grant1_s;
    logic              hs_s;
    logic [DATA_W-1:0] win_data_s;
    logic [DATA_W-1:0] win_key_s;

`ifdef AES_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt_r;
    logic            rsp_err_r;
    assign rsp_err = rsp_err_r;
`else
    assign rsp_err = 1'b0;
`endif

    // Grant selection: rr_ptr only breaks ties, a lone requester always wins.
    always_comb begin
        grant0_s   = req0_valid & (~rr_ptr_r | ~req1_valid);
        grant1_s   = req1_valid & (rr_ptr_r | ~req0_valid);
        hs_s       = (state_r == ST_IDLE) & (grant0_s | grant1_s);
        if (grant1_s) begin
            win_data_s = req1_data;
            win_key_s  = req1_key;
        end else begin
            win_data_s = req0_data;
            win_key_s  = req0_key;
        end
    end

    assign req0_ready = (state_r == ST_IDLE) & grant0_s;
    assign req1_ready = (state_r == ST_IDLE) & grant1_s;

    // Job sequencing FSM with registered core and response outputs.
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= 1'b0;
            id_r         <= 1'b0;
            gap_cnt_r    <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_data     <= '0;
            core_en      <= 1'b0;
            core_data_in <= '0;
            core_key_in  <= '0;
`ifdef AES_TIMEOUT_EN
            to_cnt_r     <= '0;
            rsp_err_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        core_data_in <= win_data_s;
                        core_key_in  <= win_key_s;
                        id_r         <= grant1_s;
                        rr_ptr_r     <= ~grant1_s;
                        core_en      <= 1'b1;
                        state_r      <= ST_RUN;
`ifdef AES_TIMEOUT_EN
                        to_cnt_r     <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    // A core result on the expiry cycle takes priority over the abort.
                    if (core_data_out_valid) begin
                        rsp_data  <= core_data_out;
                        rsp_id    <= id_r;
                        rsp_valid <= 1'b1;
                        core_en   <= 1'b0;
                        state_r   <= ST_RESP;
`ifdef AES_TIMEOUT_EN
                        rsp_err_r <= 1'b0;
`endif
                    end
`ifdef AES_TIMEOUT_EN
                    else if (to_cnt_r == TO_LAST) begin
                        rsp_data  <= '0;
                        rsp_id    <= id_r;
                        rsp_err_r <= 1'b1;
                        rsp_valid <= 1'b1;
                        core_en   <= 1'b0;
                        state_r   <= ST_RESP;
                    end else begin
                        to_cnt_r  <= to_cnt_r + TO_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        gap_cnt_r <= '0;
                        state_r   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Scoreboard bench for aes_core_arbiter with a behavioural AES core stand-in.
// The stand-in returns the FIPS-197 ciphertext for the FIPS vector and a keyed mix otherwise.

module tb_aes_core_arbiter;

    localparam int LAT         = 10;
    localparam int CORE_GAP    = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam logic [127:0] FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] SPUR_DATA = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    typedef struct packed {
        logic         id;
        logic [127:0] data;
        logic         err;
    } exp_t;

    logic         AES_clk;
    logic         AES_rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [127:0] req0_data, req1_data, req0_key, req1_key;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [127:0] rsp_data;
    logic         core_en;
    logic [127:0] core_data_in, core_key_in, core_data_out;
    logic         core_data_out_valid;

    logic         core_vld_m, spur, stall;
    logic [127:0] core_out_m;
    exp_t         exp_q[$];
    exp_t         e;
    logic         got;
    logic [127:0] last_data;
    int           n_vec, n_miss;

    aes_core_arbiter dut (
        .AES_clk(AES_clk), .AES_rst(AES_rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_key(req0_key), .req1_key(req1_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_en(core_en), .core_data_in(core_data_in), .core_key_in(core_key_in),
        .core_data_out(core_data_out), .core_data_out_valid(core_data_out_valid)
    );

    assign core_data_out_valid = core_vld_m | spur;
    assign core_data_out       = spur ? SPUR_DATA : core_out_m;

    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ {key[63:0], key[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    initial begin
        AES_clk = 1'b0;
        forever #5 AES_clk = ~AES_clk;
    end

    // Core stand-in: fixed latency after core_en, one-cycle result pulse.
    initial begin
        int cm_cnt;
        cm_cnt = 0; core_vld_m = 1'b0; core_out_m = '0;
        forever begin
            @(negedge AES_clk);
            if (core_en && !stall) begin
                cm_cnt++;
                if (cm_cnt == LAT) begin
                    core_vld_m = 1'b1;
                    core_out_m = core_fn(core_data_in, core_key_in);
                end else begin
                    core_vld_m = 1'b0;
                end
            end else begin
                cm_cnt = 0;
                core_vld_m = 1'b0;
            end
        end
    end

    task automatic send(input logic id, input logic [127:0] d, input logic [127:0] k, input logic err_exp);
        logic hs;
        exp_t x;
        hs = 1'b0;
        if (id) begin req1_data = d; req1_key = k; req1_valid = 1'b1; end
        else    begin req0_data = d; req0_key = k; req0_valid = 1'b1; end
        for (int i = 0; i < 200; i++) begin
            @(negedge AES_clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin hs = 1'b1; break; end
        end
        n_vec++;
        if (!hs) begin
            n_miss++;
            $display("FAIL send_handshake: req%0d got no ready, want ready", id);
        end else begin
            x.id = id; x.err = err_exp; x.data = err_exp ? 128'h0 : core_fn(d, k);
            exp_q.push_back(x);
        end
        @(posedge AES_clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_reset;
        AES_rst = 1'b1;
        repeat (3) @(posedge AES_clk);
        #1;
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_err} !== 3'b000 || rsp_data !== 128'h0) begin
            n_miss++;
            $display("FAIL reset_rsp: got v=%0d id=%0d err=%0d data=%h, want all 0", rsp_valid, rsp_id, rsp_err, rsp_data);
        end
        n_vec++;
        if (core_en !== 1'b0 || core_data_in !== 128'h0 || core_key_in !== 128'h0) begin
            n_miss++;
            $display("FAIL reset_core: got en=%0d din=%h key=%h, want all 0", core_en, core_data_in, core_key_in);
        end
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_miss++;
            $display("FAIL reset_ready: got %b, want 00", {req0_ready, req1_ready});
        end
        AES_rst = 1'b0;
        @(posedge AES_clk); #1;
    endtask

    task automatic test_fips;
        exp_t x;
        rsp_ready = 1'b1;
        req0_data = FIPS_PT; req0_key = FIPS_KEY; req0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge AES_clk);
            if (req0_ready === 1'b1) begin got = 1'b1; break; end
        end
        n_vec++;
        if (!got || core_en !== 1'b0) begin
            n_miss++;
            $display("FAIL fips_handshake: got ready=%0d core_en=%0d, want ready=1 core_en=0", got, core_en);
        end else begin
            x.id = 1'b0; x.data = FIPS_CT; x.err = 1'b0;
            exp_q.push_back(x);
        end
        @(posedge AES_clk); #1;
        req0_valid = 1'b0;
        n_vec++;
        if (core_en !== 1'b1 || core_data_in !== FIPS_PT || core_key_in !== FIPS_KEY) begin
            n_miss++;
            $display("FAIL fips_core_drive: got en=%0d din=%h key=%h, want 1 %h %h", core_en, core_data_in, core_key_in, FIPS_PT, FIPS_KEY);
        end
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge AES_clk);
            if (rsp_valid && rsp_ready) begin got = 1'b1; break; end
        end
        n_vec++;
        if (!got || exp_q.size() == 0) begin
            n_miss++; $display("FAIL fips_rsp: got no response, want one");
        end else begin
            e = exp_q.pop_front(); last_data = e.data;
            if (rsp_id !== e.id || rsp_data !== e.data || rsp_err !== e.err) begin
                n_miss++;
                $display("FAIL fips_rsp: got id=%0d data=%h err=%0d, want id=%0d data=%h err=%0d", rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] d0, k0, d1, k1;
        int hs_n, rsp_n, jobs0, jobs1, low_cnt;
        logic both_seen, started, upd0, upd1;
        exp_t x;
        @(posedge AES_clk); #1;
        AES_rst = 1'b1;
        @(posedge AES_clk); #1;
        AES_rst = 1'b0;
        d0 = 128'h0123456789abcdef0011223344556677; k0 = 128'hffeeddccbbaa99887766554433221100;
        d1 = 128'hcafef00d12345678a5a5a5a55a5a5a5a; k1 = 128'h13579bdf2468ace0fedcba9876543210;
        req0_data = d0; req0_key = k0; req1_data = d1; req1_key = k1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        hs_n = 0; rsp_n = 0; jobs0 = 0; jobs1 = 0; low_cnt = 0;
        both_seen = 1'b0; started = 1'b0;
        for (int cyc = 0; cyc < 600 && rsp_n < 4; cyc++) begin
            @(negedge AES_clk);
            upd0 = 1'b0; upd1 = 1'b0;
            if (req0_ready && req1_ready) both_seen = 1'b1;
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                x.id = req1_valid && req1_ready; x.err = 1'b0;
                x.data = x.id ? core_fn(req1_data, req1_key) : core_fn(req0_data, req0_key);
                n_vec++;
                if (x.id !== hs_n[0]) begin
                    n_miss++;
                    $display("FAIL b2b_order: handshake %0d got id=%0d, want id=%0d", hs_n, x.id, hs_n[0]);
                end
                exp_q.push_back(x);
                hs_n++;
                upd0 = !x.id; upd1 = x.id;
            end
            if (core_en) begin
                if (started && low_cnt > 0) begin
                    n_vec++;
                    if (low_cnt < CORE_GAP) begin
                        n_miss++;
                        $display("FAIL b2b_gap: got core_en low %0d cycles, want >= %0d", low_cnt, CORE_GAP);
                    end
                end
                started = 1'b1; low_cnt = 0;
            end else begin
                low_cnt++;
            end
            if (rsp_valid && rsp_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++; $display("FAIL b2b_rsp: got unexpected response id=%0d, want none", rsp_id);
                end else begin
                    e = exp_q.pop_front(); last_data = e.data;
                    if (rsp_id !== e.id || rsp_data !== e.data || rsp_err !== e.err) begin
                        n_miss++;
                        $display("FAIL b2b_rsp: got id=%0d data=%h err=%0d, want id=%0d data=%h err=%0d", rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
                    end
                end
                rsp_n++;
            end
            @(posedge AES_clk); #1;
            if (upd0) begin
                jobs0++; d0 = {d0[126:0], d0[127]} ^ 128'h1111; k0 = k0 + 128'd3;
                req0_data = d0; req0_key = k0;
                if (jobs0 == 2) req0_valid = 1'b0;
            end
            if (upd1) begin
                jobs1++; d1 = {d1[0], d1[127:1]} ^ 128'h2222; k1 = k1 + 128'd5;
                req1_data = d1; req1_key = k1;
                if (jobs1 == 2) req1_valid = 1'b0;
            end
        end
        n_vec++;
        if (rsp_n != 4 || both_seen !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_summary: got %0d responses both_ready=%0d, want 4 responses both_ready=0", rsp_n, both_seen);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_hold;
        exp_t x;
        rsp_ready = 1'b0;
        send(1'b1, 128'h89abcdef0123456789abcdef01234567, 128'h0badc0de0badc0de0badc0de0badc0de, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge AES_clk);
            if (rsp_valid) begin got = 1'b1; break; end
        end
        @(posedge AES_clk); #1;
        req0_data = 128'h55aa55aa55aa55aa0123012301230123; req0_key = 128'h77777777888888889999999966666666;
        req0_valid = 1'b1;
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge AES_clk);
            n_vec++;
            if (!got || rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data || rsp_err !== e.err || core_en !== 1'b0 || req0_ready !== 1'b0) begin
                n_miss++;
                $display("FAIL hold_stable: cyc %0d got v=%0d id=%0d data=%h en=%0d rdy0=%0d, want 1 %0d %h 0 0", i, rsp_valid, rsp_id, rsp_data, core_en, req0_ready, e.id, e.data);
            end
        end
        @(posedge AES_clk); #1;
        rsp_ready = 1'b1;
        @(negedge AES_clk);
        n_vec++;
        if (!(rsp_valid && rsp_ready) || exp_q.size() == 0) begin
            n_miss++; $display("FAIL hold_rsp: got v=%0d, want accepted response", rsp_valid);
        end else begin
            e = exp_q.pop_front(); last_data = e.data;
            if (rsp_id !== e.id || rsp_data !== e.data || rsp_err !== e.err) begin
                n_miss++;
                $display("FAIL hold_rsp: got id=%0d data=%h err=%0d, want id=%0d data=%h err=%0d", rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
            end
        end
        for (int g = 0; g < CORE_GAP; g++) begin
            @(negedge AES_clk);
            n_vec++;
            if (req0_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                n_miss++;
                $display("FAIL hold_gap: gap cyc %0d got rdy0=%0d v=%0d, want 0 0", g, req0_ready, rsp_valid);
            end
        end
        @(negedge AES_clk);
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_miss++; $display("FAIL hold_regrant: got rdy0=%0d, want 1", req0_ready);
        end else begin
            x.id = 1'b0; x.err = 1'b0; x.data = core_fn(req0_data, req0_key);
            exp_q.push_back(x);
        end
        @(posedge AES_clk); #1;
        req0_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge AES_clk);
            if (rsp_valid && rsp_ready) begin got = 1'b1; break; end
        end
        n_vec++;
        if (!got || exp_q.size() == 0) begin
            n_miss++; $display("FAIL hold_next_rsp: got no response, want one");
        end else begin
            e = exp_q.pop_front(); last_data = e.data;
            if (rsp_id !== e.id || rsp_data !== e.data || rsp_err !== e.err) begin
                n_miss++;
                $display("FAIL hold_next_rsp: got id=%0d data=%h err=%0d, want id=%0d data=%h err=%0d", rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
            end
        end
    endtask

    task automatic test_spurious;
        repeat (4) begin @(posedge AES_clk); #1; end
        spur = 1'b1;
        @(posedge AES_clk); #1;
        spur = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge AES_clk);
            n_vec++;
            if (rsp_valid !== 1'b0 || core_en !== 1'b0 || rsp_data !== last_data) begin
                n_miss++;
                $display("FAIL spur_idle: got v=%0d en=%0d data=%h, want 0 0 %h", rsp_valid, core_en, rsp_data, last_data);
            end
        end
        @(posedge AES_clk); #1;
        rsp_ready = 1'b1;
        send(1'b0, 128'h00000000111111112222222233333333, 128'h44444444555555556666666677777777, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge AES_clk);
            if (rsp_valid && rsp_ready) begin got = 1'b1; break; end
        end
        n_vec++;
        if (!got || exp_q.size() == 0) begin
            n_miss++; $display("FAIL spur_job_rsp: got no response, want one");
        end else begin
            e = exp_q.pop_front(); last_data = e.data;
            if (rsp_id !== e.id || rsp_data !== e.data || rsp_err !== e.err) begin
                n_miss++;
                $display("FAIL spur_job_rsp: got id=%0d data=%h err=%0d, want id=%0d data=%h err=%0d", rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
            end
        end
        @(posedge AES_clk); #1;
        spur = 1'b1;
        repeat (CORE_GAP) begin @(posedge AES_clk); #1; end
        spur = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge AES_clk);
            n_vec++;
            if (rsp_valid !== 1'b0 || core_en !== 1'b0 || rsp_data !== last_data) begin
                n_miss++;
                $display("FAIL spur_gap: got v=%0d en=%0d data=%h, want 0 0 %h", rsp_valid, core_en, rsp_data, last_data);
            end
        end
        @(posedge AES_clk); #1;
    endtask

    task automatic test_reset_mid;
        rsp_ready = 1'b1;
        send(1'b0, 128'hfedcba98765432100123456789abcdef, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        repeat (3) begin @(posedge AES_clk); #1; end
        n_vec++;
        if (core_en !== 1'b1) begin
            n_miss++; $display("FAIL rstmid_run: got core_en=%0d, want 1", core_en);
        end
        AES_rst = 1'b1;
        @(posedge AES_clk); #1;
        AES_rst = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_err, core_en} !== 4'b0000 || rsp_data !== 128'h0 || core_data_in !== 128'h0 || core_key_in !== 128'h0) begin
            n_miss++;
            $display("FAIL rstmid_clear: got v=%0d en=%0d data=%h din=%h key=%h, want all 0", rsp_valid, core_en, rsp_data, core_data_in, core_key_in);
        end
        if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge AES_clk);
            if (rsp_valid) got = 1'b1;
        end
        n_vec++;
        if (got !== 1'b0) begin
            n_miss++; $display("FAIL rstmid_ghost: got rsp_valid=1 after reset, want 0");
        end
        @(posedge AES_clk); #1;
        send(1'b1, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge AES_clk);
            if (rsp_valid && rsp_ready) begin got = 1'b1; break; end
        end
        n_vec++;
        if (!got || exp_q.size() == 0) begin
            n_miss++; $display("FAIL rstmid_next_rsp: got no response, want one");
        end else begin
            e = exp_q.pop_front(); last_data = e.data;
            if (rsp_id !== e.id || rsp_data !== e.data || rsp_err !== e.err) begin
                n_miss++;
                $display("FAIL rstmid_next_rsp: got id=%0d data=%h err=%0d, want id=%0d data=%h err=%0d", rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
            end
        end
    endtask

    task automatic test_timeout;
        int run_n;
        @(posedge AES_clk); #1;
        rsp_ready = 1'b1;
        stall = 1'b1;
        send(1'b0, 128'h11223344556677881122334455667788, 128'h99aabbccddeeff0099aabbccddeeff00, 1'b1);
        run_n = 0;
        got = 1'b0;
`ifdef AES_TIMEOUT_EN
        for (int i = 0; i < 300; i++) begin
            @(negedge AES_clk);
            if (rsp_valid) begin got = 1'b1; break; end
            if (core_en) run_n++;
        end
        n_vec++;
        if (!got || exp_q.size() == 0 || run_n != TIMEOUT_CYC) begin
            n_miss++;
            $display("FAIL timeout_abort: got rsp=%0d after %0d RUN cycles, want rsp after %0d", got, run_n, TIMEOUT_CYC);
        end
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rsp_id !== e.id || rsp_data !== e.data || rsp_err !== e.err || core_en !== 1'b0) begin
                n_miss++;
                $display("FAIL timeout_rsp: got id=%0d data=%h err=%0d en=%0d, want id=%0d data=%h err=%0d en=0", rsp_id, rsp_data, rsp_err, core_en, e.id, e.data, e.err);
            end
        end
        stall = 1'b0;
        @(posedge AES_clk); #1;
`else
        for (int i = 0; i < 150; i++) begin
            @(negedge AES_clk);
            if (rsp_valid) got = 1'b1;
            if (core_en) run_n++;
        end
        n_vec++;
        if (got !== 1'b0 || run_n != 150) begin
            n_miss++;
            $display("FAIL no_timeout: got rsp=%0d core_en cycles=%0d, want rsp=0 core_en cycles=150", got, run_n);
        end
        if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        stall = 1'b0;
        @(posedge AES_clk); #1;
        AES_rst = 1'b1;
        @(posedge AES_clk); #1;
        AES_rst = 1'b0;
`endif
    endtask

    initial begin
        n_vec = 0; n_miss = 0; last_data = '0;
        AES_rst = 1'b1; spur = 1'b0; stall = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; req0_key = '0; req1_key = '0;
        test_reset();
        test_fips();
        test_back_to_back();
        test_hold();
        test_spurious();
        test_reset_mid();
        test_timeout();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++; $display("FAIL leftover_expected: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
